float_to_int16_stream: RTL and testbench
========================================

FLOAT_TO_INT16_STREAM -- requirements
Module: float_to_int16_stream

Interface
REQ-001 SHALL have parameter: MSB_FIRST, 1, input float bytes arrive sign/exponent byte first (0 = LSB byte first); output int16 is always MSB first.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_byte  input  8  IEEE-754 single-precision byte.
REQ-005 SHALL have port: in_valid  input  1  in_byte valid.
REQ-006 SHALL have port: in_ready  output  1  block accepts in_byte this cycle.
REQ-007 SHALL have port: out_byte  output  8  int16 result byte.
REQ-008 SHALL have port: out_valid  output  1  out_byte valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes out_byte this cycle.
REQ-010 SHALL have port: busy  output  1  high whenever a word is partially loaded, converting or being output.
REQ-011 SHALL have port: sat  output  1  last result was saturated or NaN-forced; valid while out_valid.

Function
REQ-012 SHALL use states LOAD0, LOAD1, LOAD2, LOAD3, DECODE, SHIFT, OUT_MSB, OUT_LSB.
REQ-013 SHALL transfer a byte only when in_valid and in_ready are both high; in_ready SHALL be high exactly in LOAD0..LOAD3.
REQ-014 SHALL advance LOADn -> LOADn+1 on each transfer; LOAD3 transfer -> DECODE; no transfer -> hold state.
REQ-015 SHALL proceed DECODE -> SHIFT -> OUT_MSB unconditionally, one cycle each; out_valid first high 3 cycles after the 4th byte transfer edge.
REQ-016 SHALL hold out_valid high in OUT_MSB and OUT_LSB; advance OUT_MSB -> OUT_LSB -> LOAD0 only on out_valid and out_ready; out_byte and sat SHALL stay stable while stalled.
REQ-017 SHALL decode sign s, exponent field E, mantissa m, e = E - 127; magnitude = {1,m} >> (23 - e) for 0 <= e <= 14.
REQ-018 SHALL return 0 for e < 0, including zero and denormals, sat = 0.
REQ-019 SHALL return 0x7FFF (s=0) or 0x8000 (s=1) with sat = 1 for e >= 15 or E = 255 with m = 0, except exactly -32768.0 (s=1, e=15, m=0) which returns 0x8000 with sat = 0.
REQ-020 SHALL return 0x0000 with sat = 1 for NaN (E = 255, m != 0).
REQ-021 SHALL round toward zero by default, then two's-complement negate when s = 1.
REQ-022 SHALL keep busy low only in LOAD0 with no word in progress; out_valid SHALL be low in all other states.

Reset
REQ-023 SHALL, while reset is high, force state LOAD0, in_ready 0, out_valid 0, out_byte 0x00, sat 0, busy 0, and clear the byte assembly register.
REQ-024 SHALL raise in_ready on the first rising clk edge after reset deasserts.
REQ-025 SHALL discard any partially loaded or unsent word on reset mid-operation; the next 4 accepted bytes form a fresh word.

Configuration
REQ-026 SHALL, when FLOAT_TO_INT16_ROUND_EN is defined, round to nearest with ties to even using guard and sticky bits, including e = -1 (0.5 < |x| < 1 rounds to ±1, exactly 0.5 rounds to 0); a rounded positive magnitude above 32767 SHALL saturate with sat = 1.
REQ-027 SHALL, when FLOAT_TO_INT16_ROUND_EN is undefined, truncate toward zero with no rounding logic present.

Verification
REQ-028 SHALL pass: bytes 3F 80 00 00 (1.0) -> out bytes 00, 01, sat 0; bytes C2 F6 00 00 (-123.0) -> FF, 85, sat 0.
REQ-029 SHALL pass: 47 80 00 00 (65536.0) -> 7F, FF, sat 1; C7 00 00 00 (-32768.0) -> 80, 00, sat 0; 7F C0 00 00 (NaN) -> 00, 00, sat 1.
REQ-030 SHALL pass: 40 20 00 00 (2.5) and 40 60 00 00 (3.5) -> 0x0002 and 0x0003 without the macro; 0x0002 and 0x0004 with FLOAT_TO_INT16_ROUND_EN defined.
REQ-031 SHALL pass: out_ready held low 5 cycles in OUT_MSB -> out_byte, out_valid and sat stable, in_ready 0; then out_ready high -> both bytes delivered in 2 cycles, then in_ready 1.
REQ-032 SHALL pass: in_valid gaps of 0-3 cycles between bytes -> same results as back-to-back input; out_valid exactly 3 cycles after the 4th transfer.
REQ-033 SHALL pass: reset pulsed after 2 bytes of 3F 80 00 00, then bytes C2 F6 00 00 -> FF, 85.

Source files
------------

// File: rtl/float_to_int16_stream_if.sv
// ---------------------------------------------------------------------------
// float_to_int16_stream_if
//
// Groups the byte-stream handshakes and status flags of float_to_int16_stream.
//
// Signals:
//   in_byte   [7:0]  IEEE-754 single-precision byte from the producer
//   in_valid         in_byte is valid
//   in_ready         converter accepts in_byte this cycle
//   out_byte  [7:0]  int16 result byte, MSB first
//   out_valid        out_byte is valid
//   out_ready        consumer takes out_byte this cycle
//   busy             a word is partially loaded, converting or being output
//   sat              last result was saturated or NaN-forced
//
// Modports:
//   slave  - the converter's view (consumes input stream, produces output)
//   master - the environment's view (drives input stream, consumes output)
// ---------------------------------------------------------------------------
interface float_to_int16_stream_if;

    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       sat;

    modport slave (
        input  in_byte,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_byte,
        output out_valid,
        output busy,
        output sat
    );

    modport master (
        output in_byte,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_byte,
        input  out_valid,
        input  busy,
        input  sat
    );

endinterface

// File: rtl/float_to_int16_stream.sv
// ---------------------------------------------------------------------------
// float_to_int16_stream
//
// Collects four bytes of an IEEE-754 single-precision float from a
// valid/ready byte stream, converts the value to a signed 16-bit integer and
// sends the result as two bytes (MSB first) on a second valid/ready stream.
//
// Parameters:
//   MSB_FIRST  1: the sign/exponent byte arrives first; 0: LSB byte first
//
// Ports:
//   clk    single clock, all logic on the rising edge
//   reset  asynchronous, active-high reset
//   bus    float_to_int16_stream_if.slave
//            in_byte/in_valid/in_ready     float byte input stream
//            out_byte/out_valid/out_ready  int16 byte output stream
//            busy                          word loading, converting or output
//            sat                           result saturated or NaN-forced
//
// Conversion:
//   Zero, denormals and |x| < 1 give 0. Magnitudes that do not fit give
//   0x7FFF / 0x8000 with sat set (exactly -32768.0 is representable and is
//   not flagged). NaN gives 0x0000 with sat set.
//
// Configuration macro:
//   FLOAT_TO_INT16_ROUND_EN  defined   : round to nearest, ties to even
//                            undefined : truncate toward zero
// ---------------------------------------------------------------------------
module float_to_int16_stream #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    float_to_int16_stream_if.slave        bus
);

    typedef enum logic [2:0] {
        LOAD0   = 3'd0,
        LOAD1   = 3'd1,
        LOAD2   = 3'd2,
        LOAD3   = 3'd3,
        DECODE  = 3'd4,
        SHIFT   = 3'd5,
        OUT_MSB = 3'd6,
        OUT_LSB = 3'd7
    } state_t;

    // Exponent field at which |x| >= 32768, and the smallest exponent field
    // that can still produce a non-zero result. With rounding, e = -1
    // (0.5 <= |x| < 1) may round up to 1, so it joins the shifting path.
    localparam logic [7:0] EXP_SAT = 8'd142;
`ifdef FLOAT_TO_INT16_ROUND_EN
    localparam logic [7:0] EXP_MIN = 8'd126;
`else
    localparam logic [7:0] EXP_MIN = 8'd127;
`endif

    state_t      state_q, state_d;
    logic        readyEn_q;
    logic [31:0] word_q, word_d;

    logic        sign_q, sign_d;
    logic [23:0] mant_q, mant_d;
    logic [4:0]  shamt_q, shamt_d;
    logic        special_q, special_d;
    logic [15:0] specRes_q, specRes_d;
    logic        specSat_q, specSat_d;

    logic [15:0] result_q, result_d;
    logic        sat_q, sat_d;

    logic        loadState;
    logic        outState;
    logic        inReady;
    logic        accept;
    logic        outFire;
    logic [1:0]  loadIdx;
    logic [1:0]  lane;
    logic [7:0]  expField;
    logic [22:0] mantField;
    logic [15:0] mag;
`ifdef FLOAT_TO_INT16_ROUND_EN
    logic [23:0] frac;
`endif

    // Handshake qualifiers. in_ready stays low until the first clock edge
    // after reset is released, which readyEn_q provides.
    assign loadState = (state_q == LOAD0) || (state_q == LOAD1) ||
                       (state_q == LOAD2) || (state_q == LOAD3);
    assign outState  = (state_q == OUT_MSB) || (state_q == OUT_LSB);
    assign inReady   = readyEn_q && loadState;
    assign accept    = bus.in_valid && inReady;
    assign outFire   = outState && bus.out_ready;

    // Next-state logic. Loading advances one state per accepted byte, the
    // two conversion stages take one cycle each, and the output states only
    // move on when the consumer takes the byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD0:   if (accept)  state_d = LOAD1;
            LOAD1:   if (accept)  state_d = LOAD2;
            LOAD2:   if (accept)  state_d = LOAD3;
            LOAD3:   if (accept)  state_d = DECODE;
            DECODE:               state_d = SHIFT;
            SHIFT:                state_d = OUT_MSB;
            OUT_MSB: if (outFire) state_d = OUT_LSB;
            OUT_LSB: if (outFire) state_d = LOAD0;
            default:              state_d = LOAD0;
        endcase
    end

    // Byte assembly. The load state number is the arrival index; with the
    // sign/exponent byte first, index 0 lands in the top byte lane, which is
    // simply the inverted index.
    assign loadIdx = state_q[1:0];
    assign lane    = MSB_FIRST ? ~loadIdx : loadIdx;

    always_comb begin
        word_d = word_q;
        if (accept) begin
            word_d[{lane, 3'b000} +: 8] = bus.in_byte;
        end
    end

    // Decode stage: classify the float and precompute either a fixed result
    // (zero, saturation, NaN) or the right-shift that moves the binary point
    // of {1,m} to bit 0. The shift is 23 - e = 150 - E.
    assign expField  = word_q[30:23];
    assign mantField = word_q[22:0];

    always_comb begin
        sign_d    = sign_q;
        mant_d    = mant_q;
        shamt_d   = shamt_q;
        special_d = special_q;
        specRes_d = specRes_q;
        specSat_d = specSat_q;
        if (state_q == DECODE) begin
            sign_d    = word_q[31];
            mant_d    = {1'b1, mantField};
            shamt_d   = 5'd0;
            special_d = 1'b1;
            specRes_d = 16'h0000;
            specSat_d = 1'b0;
            if ((expField == 8'hFF) && (mantField != 23'd0)) begin
                specSat_d = 1'b1;
            end else if (expField >= EXP_SAT) begin
                if (word_q[31] && (expField == EXP_SAT) && (mantField == 23'd0)) begin
                    specRes_d = 16'h8000;
                end else begin
                    specRes_d = word_q[31] ? 16'h8000 : 16'h7FFF;
                    specSat_d = 1'b1;
                end
            end else if (expField >= EXP_MIN) begin
                special_d = 1'b0;
                shamt_d   = 5'(8'd150 - expField);
            end
        end
    end

    // Shift stage: align the mantissa, optionally round, then apply the
    // sign. With rounding, the bits shifted out form the fraction: its top
    // bit is the guard bit and the rest is the sticky OR. A positive value
    // rounded up past 32767 cannot be represented and saturates; a negative
    // one reaching 32768 is exactly -32768 and is fine.
    always_comb begin
        result_d = result_q;
        sat_d    = sat_q;
        mag      = 16'(mant_q >> shamt_q);
`ifdef FLOAT_TO_INT16_ROUND_EN
        frac     = 24'({mant_q, 24'd0} >> shamt_q);
        if (frac[23] && ((|frac[22:0]) || mag[0])) begin
            mag = mag + 16'd1;
        end
`endif
        if (state_q == SHIFT) begin
            if (special_q) begin
                result_d = specRes_q;
                sat_d    = specSat_q;
            end else begin
                result_d = sign_q ? (~mag + 16'd1) : mag;
                sat_d    = 1'b0;
`ifdef FLOAT_TO_INT16_ROUND_EN
                if (!sign_q && mag[15]) begin
                    result_d = 16'h7FFF;
                    sat_d    = 1'b1;
                end
`endif
            end
        end
    end

    // Output drive. out_byte is zero outside the output states so that it
    // reads 0x00 during and after reset; sat holds the last result flag.
    always_comb begin
        bus.in_ready  = inReady;
        bus.out_valid = outState;
        bus.busy      = (state_q != LOAD0);
        bus.sat       = sat_q;
        bus.out_byte  = 8'h00;
        if (state_q == OUT_MSB) begin
            bus.out_byte = result_q[15:8];
        end else if (state_q == OUT_LSB) begin
            bus.out_byte = result_q[7:0];
        end
    end

    // State and datapath registers. Reset drops any word in flight and
    // clears the assembly register so the next four bytes start fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOAD0;
            readyEn_q <= 1'b0;
            word_q    <= 32'd0;
            sign_q    <= 1'b0;
            mant_q    <= 24'd0;
            shamt_q   <= 5'd0;
            special_q <= 1'b0;
            specRes_q <= 16'h0000;
            specSat_q <= 1'b0;
            result_q  <= 16'h0000;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            readyEn_q <= 1'b1;
            word_q    <= word_d;
            sign_q    <= sign_d;
            mant_q    <= mant_d;
            shamt_q   <= shamt_d;
            special_q <= special_d;
            specRes_q <= specRes_d;
            specSat_q <= specSat_d;
            result_q  <= result_d;
            sat_q     <= sat_d;
        end
    end

endmodule

// File: tb/tb_float_to_int16_stream.sv
// Self-checking bench for float_to_int16_stream. Expected results come from
// a real-arithmetic model and travel through a scoreboard queue.
module tb_float_to_int16_stream;

    logic clk = 1'b0;
    logic reset;

    float_to_int16_stream_if bus();

    float_to_int16_stream #(.MSB_FIRST(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       sat;
    } expect_t;

    expect_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    // Reference conversion using real arithmetic on the decoded value.
    function automatic void modelConvert(input logic [31:0] f, output logic [15:0] r, output logic s);
        int  e;
        int  q;
        real a;
        real fr;
        e = int'(f[30:23]) - 127;
        if ((f[30:23] == 8'hFF) && (f[22:0] != 23'd0)) begin
            r = 16'h0000; s = 1'b1; return;
        end
        if (f[30:23] == 8'hFF) begin
            r = f[31] ? 16'h8000 : 16'h7FFF; s = 1'b1; return;
        end
        if (f[30:23] == 8'h00) a = 0.0;
        else a = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** e);
        if (f[31] && (a == 32768.0)) begin
            r = 16'h8000; s = 1'b0; return;
        end
        if (a >= 32768.0) begin
            r = f[31] ? 16'h8000 : 16'h7FFF; s = 1'b1; return;
        end
        q = $rtoi(a);
`ifdef FLOAT_TO_INT16_ROUND_EN
        fr = a - real'(q);
        if ((fr > 0.5) || ((fr == 0.5) && (q % 2 == 1))) q = q + 1;
        if (!f[31] && (q > 32767)) begin
            r = 16'h7FFF; s = 1'b1; return;
        end
`else
        fr = 0.0;
`endif
        r = f[31] ? 16'(-q) : 16'(q);
        s = 1'b0;
    endfunction

    // Offers one byte after 'gap' idle cycles and waits for its transfer.
    // Called and returns #1 after a rising edge.
    task automatic sendByte(input logic [7:0] b, input int gap, output bit ok);
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Sends a float word MSB first; optionally pushes its expected result.
    task automatic sendWord(input logic [31:0] w, input bit randGaps, input bit push);
        expect_t     e;
        logic [15:0] r;
        logic        s;
        bit          bok;
        bit          ok;
        if (push) begin
            modelConvert(w, r, s);
            e.hi = r[15:8]; e.lo = r[7:0]; e.sat = s;
            sb.push_back(e);
        end
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sendByte(w[31 - 8*i -: 8], randGaps ? int'($urandom_range(0, 3)) : 0, bok);
            if (!bok) ok = 1'b0;
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL send_word %h: got in_ready timeout, want all 4 bytes accepted", w);
        end
    endtask

    // Gathers both output bytes; lat counts cycles from the 4th transfer.
    task automatic collectResult(output logic [7:0] hi, output logic [7:0] lo, output logic s,
                                 output int lat, output bit ok);
        int got;
        hi = 8'hxx; lo = 8'hxx; s = 1'bx; lat = -1; got = 0;
        for (int n = 1; n <= 50 && got < 2; n++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (got == 0) begin
                    hi = bus.out_byte; s = bus.sat; lat = n;
                end else begin
                    lo = bus.out_byte;
                end
                got++;
            end
        end
        ok = (got == 2);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.sat} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got rdy/vld/busy/sat=%b want 0000",
                     {bus.in_ready, bus.out_valid, bus.busy, bus.sat});
        end
        compared++;
        if (bus.out_byte !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_out_byte: got %h want 00", bus.out_byte);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ready_before_edge: got %b want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        compared++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ready_after_edge: got rdy=%b busy=%b want rdy=1 busy=0",
                     bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vec [] = '{
            32'h3F800000, 32'hC2F60000, 32'h47800000, 32'hC7000000, 32'h7FC00000,
            32'h40200000, 32'h40600000, 32'h00000000, 32'h80000000, 32'h00000001,
            32'h3F400000, 32'hBF000000, 32'h3F000000, 32'hBFC00000, 32'h46FFFE00,
            32'h46FFFF00, 32'hC7000080, 32'hC6FFFF00, 32'h7F800000, 32'hFF800000,
            32'h4640E6B7, 32'h477FFF00, 32'h3F7FFFFF, 32'hC0200000};
        logic [31:0] w;
        logic [7:0]  hi, lo;
        logic        s;
        int          lat;
        bit          cok;
        expect_t     e;
        for (int i = 0; i < vec.size() + 16; i++) begin
            if (i < vec.size()) w = vec[i];
            else w = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 150)), 23'($urandom)};
            sendWord(w, 1'b0, 1'b1);
            collectResult(hi, lo, s, lat, cok);
            e = sb.pop_front();
            compared++;
            if (!cok || hi !== e.hi || lo !== e.lo) begin
                mismatched++;
                $display("[TB] FAIL vector_%h: got %h%h want %h%h", w, hi, lo, e.hi, e.lo);
            end
            compared++;
            if (s !== e.sat) begin
                mismatched++;
                $display("[TB] FAIL vector_sat_%h: got %b want %b", w, s, e.sat);
            end
            compared++;
            if (lat != 3) begin
                mismatched++;
                $display("[TB] FAIL vector_latency_%h: got %0d want 3", w, lat);
            end
        end
    endtask

    task automatic test_gaps();
        logic [31:0] vec [] = '{32'h3F800000, 32'hC2F60000, 32'h40600000, 32'hC7000000,
                                32'h7FC00000, 32'h46FFFE00, 32'hBFC00000, 32'h47800000};
        logic [7:0] hi, lo;
        logic       s;
        int         lat;
        bit         cok;
        expect_t    e;
        foreach (vec[i]) begin
            sendWord(vec[i], 1'b1, 1'b1);
            collectResult(hi, lo, s, lat, cok);
            e = sb.pop_front();
            compared++;
            if (!cok || hi !== e.hi || lo !== e.lo || s !== e.sat) begin
                mismatched++;
                $display("[TB] FAIL gaps_%h: got %h%h sat=%b want %h%h sat=%b",
                         vec[i], hi, lo, s, e.hi, e.lo, e.sat);
            end
            compared++;
            if (lat != 3) begin
                mismatched++;
                $display("[TB] FAIL gaps_latency_%h: got %0d want 3", vec[i], lat);
            end
        end
    endtask

    task automatic test_stall();
        expect_t e;
        int      n;
        bus.out_ready = 1'b0;
        sendWord(32'h40600000, 1'b0, 1'b1);
        e = sb.pop_front();
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            @(negedge clk);
            if (bus.out_valid) n = k;
        end
        compared++;
        if (n != 3) begin
            mismatched++;
            $display("[TB] FAIL stall_latency: got %0d want 3", n);
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            compared++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== e.hi || bus.sat !== e.sat || bus.in_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL stall_hold_%0d: got vld=%b byte=%h sat=%b rdy=%b want 1 %h %b 0",
                         c, bus.out_valid, bus.out_byte, bus.sat, bus.in_ready, e.hi, e.sat);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== e.lo) begin
            mismatched++;
            $display("[TB] FAIL stall_lsb: got vld=%b byte=%h want 1 %h", bus.out_valid, bus.out_byte, e.lo);
        end
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL stall_release: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] hi, lo;
        logic       s;
        int         lat;
        bit         ok;
        expect_t    e;
        sendByte(8'h3F, 0, ok);
        sendByte(8'h80, 0, ok);
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL busy_partial: got %b want 1", bus.busy);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_flags: got busy=%b rdy=%b want 0 0", bus.busy, bus.in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        sendWord(32'hC2F60000, 1'b0, 1'b1);
        collectResult(hi, lo, s, lat, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || hi !== e.hi || lo !== e.lo || s !== e.sat) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_load: got %h%h sat=%b want %h%h sat=%b", hi, lo, s, e.hi, e.lo, e.sat);
        end

        bus.out_ready = 1'b0;
        sendWord(32'hC7000080, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00 || bus.sat !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_out: got vld=%b byte=%h sat=%b want 0 00 0",
                     bus.out_valid, bus.out_byte, bus.sat);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        sendWord(32'h3F800000, 1'b1, 1'b1);
        collectResult(hi, lo, s, lat, ok);
        e = sb.pop_front();
        compared++;
        if (!ok || hi !== e.hi || lo !== e.lo || s !== e.sat) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_after_out: got %h%h sat=%b want %h%h sat=%b",
                     hi, lo, s, e.hi, e.lo, e.sat);
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish by time %0t, want finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_vectors();
        test_gaps();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
